// File: rtl/dest_hazard_scoreboard.sv
// Destination-register scoreboard for the EX/MEM/WB stages: raises the ID stall on
// hazards and, when built with FORWARDING_EN defined, drives the ALU operand bypass selects.
module dest_hazard_scoreboard #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_wr_en,
    input  logic [2:0]       id_rd,
    input  logic             id_is_load,
    input  logic [2:0]       id_rs,
    input  logic             id_rs_used,
    input  logic [2:0]       id_rt,
    input  logic             id_rt_used,
    input  logic             flush,
    input  logic             mem_stall,
    output logic             stall,
    output logic [2:0]       ex_rd,
    output logic [2:0]       mem_rd,
    output logic [2:0]       wb_rd,
    output logic             ex_wr,
    output logic             mem_wr,
    output logic             wb_wr,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       wr;
        logic [2:0] rd;
        logic       ld;
    } entry_t;

    entry_t           ex_q, ex_d, mem_q, wb_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             rs_ex, rs_mem, rt_ex, rt_mem;
    logic             hazard;

    function automatic logic hit(input logic vld, input logic used,
                                 input logic [2:0] src, input entry_t e);
        return vld && used && e.wr && (e.rd == src);
    endfunction

    always_comb begin
        rs_ex     = hit(id_valid, id_rs_used, id_rs, ex_q);
        rs_mem    = hit(id_valid, id_rs_used, id_rs, mem_q);
        rt_ex     = hit(id_valid, id_rt_used, id_rt, ex_q);
        rt_mem    = hit(id_valid, id_rt_used, id_rt, mem_q);
        hazard    = 1'b0;
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
`ifdef FORWARDING_EN
        // Only a load in EX cannot be bypassed; its data appears one stage later.
        hazard = (rs_ex || rt_ex) && ex_q.ld;
        if (rs_ex && !ex_q.ld)  fwd_a_sel = 2'b01;
        else if (rs_mem && !rs_ex) fwd_a_sel = 2'b10;
        if (rt_ex && !ex_q.ld)  fwd_b_sel = 2'b01;
        else if (rt_mem && !rt_ex) fwd_b_sel = 2'b10;
`else
        hazard = rs_ex || rs_mem || rt_ex || rt_mem;
`endif
        stall = hazard && !flush;
    end

    always_comb begin
        ex_d = '0;
        if (id_valid && !stall && !flush) begin
            ex_d = '{wr: id_wr_en, rd: id_rd, ld: id_is_load};
        end
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else if (!mem_stall) begin
            wb_q        <= mem_q;
            mem_q       <= ex_q;
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Load flags travel with the entries but only EX's is consulted, and only with bypassing.
    logic unused_ld;
`ifdef FORWARDING_EN
    assign unused_ld = mem_q.ld ^ wb_q.ld;
`else
    assign unused_ld = ex_q.ld ^ mem_q.ld ^ wb_q.ld;
`endif

    assign ex_rd     = ex_q.rd;
    assign ex_wr     = ex_q.wr;
    assign mem_rd    = mem_q.rd;
    assign mem_wr    = mem_q.wr;
    assign wb_rd     = wb_q.rd;
    assign wb_wr     = wb_q.wr;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_dest_hazard_scoreboard.sv
// Bench for dest_hazard_scoreboard: per-cycle vector table with a stage-entry queue,
// plus hand-written reset and counter-saturation sequences.
module tb_dest_hazard_scoreboard;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid, id_wr_en, id_is_load, id_rs_used, id_rt_used;
    logic [2:0]       id_rd, id_rs, id_rt;
    logic             flush, mem_stall;
    logic             stall, ex_wr, mem_wr, wb_wr;
    logic [2:0]       ex_rd, mem_rd, wb_rd;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt;

    dest_hazard_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_wr_en(id_wr_en),
        .id_rd(id_rd), .id_is_load(id_is_load), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used), .flush(flush), .mem_stall(mem_stall),
        .stall(stall), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int valid, wr, rd, ld, rs, rsu, rt, rtu, fl, ms;
        int e_stall, e_a, e_b;
    } vec_t;

    vec_t vecs[$];
    int   exp_q[$];   // {wr,rd} packed as wr*8+rd; [0]=WB [1]=MEM [2]=EX
    int   exp_cnt;
    int   total = 0;
    int   bad = 0;

    function automatic vec_t v(int valid, int wr, int rd, int ld, int rs, int rsu,
                               int rt, int rtu, int fl, int ms, int es, int ea, int eb);
        vec_t t;
        t = '{valid, wr, rd, ld, rs, rsu, rt, rtu, fl, ms, es, ea, eb};
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid   = t.valid[0]; id_wr_en = t.wr[0]; id_rd = t.rd[2:0];
        id_is_load = t.ld[0];    id_rs = t.rs[2:0];  id_rs_used = t.rsu[0];
        id_rt      = t.rt[2:0];  id_rt_used = t.rtu[0];
        flush      = t.fl[0];    mem_stall = t.ms[0];
    endtask

    task automatic model_reset();
        exp_q   = '{0, 0, 0};
        exp_cnt = 0;
    endtask

    task automatic check_stages(input string tag);
        chk({tag, " ex_wr"},  int'(ex_wr),  exp_q[2] / 8);
        chk({tag, " ex_rd"},  int'(ex_rd),  exp_q[2] % 8);
        chk({tag, " mem_wr"}, int'(mem_wr), exp_q[1] / 8);
        chk({tag, " mem_rd"}, int'(mem_rd), exp_q[1] % 8);
        chk({tag, " wb_wr"},  int'(wb_wr),  exp_q[0] / 8);
        chk({tag, " wb_rd"},  int'(wb_rd),  exp_q[0] % 8);
        chk({tag, " stall_cnt"}, int'(stall_cnt), exp_cnt);
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        string tag;
        int    nxt;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        drive(t);
        #1;
        chk({tag, " stall"}, int'(stall), t.e_stall);
        chk({tag, " fwd_a"}, int'(fwd_a_sel), t.e_a);
        chk({tag, " fwd_b"}, int'(fwd_b_sel), t.e_b);
        @(posedge clk);
        #1;
        if (t.ms == 0) begin
            nxt = (t.e_stall != 0 || t.fl != 0 || t.valid == 0) ? 0 : t.wr * 8 + t.rd;
            exp_q.push_back(nxt);
            void'(exp_q.pop_front());
            if (t.e_stall != 0 && exp_cnt < 255) exp_cnt++;
        end
        check_stages(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(v(0,0,0,0,0,0,0,0,0,0,0,0,0));
        #3;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t idle;
        idle = v(0,0,0,0,0,0,0,0,0,0,0,0,0);
`ifndef FORWARDING_EN
        for (int i = 0; i < 5; i++) vecs.push_back(idle);
        vecs.push_back(v(1,1,3,0, 1,1,2,1, 0,0, 0,0,0));   // ADD r3
        vecs.push_back(v(1,1,4,0, 3,1,1,1, 0,0, 1,0,0));   // SUB rs=r3, EX hit
        vecs.push_back(v(1,1,4,0, 3,1,1,1, 0,0, 1,0,0));   // MEM hit
        vecs.push_back(v(1,1,4,0, 3,1,1,1, 0,0, 0,0,0));   // WB not checked
        vecs.push_back(idle);
        vecs.push_back(v(1,1,6,0, 0,0,0,0, 0,0, 0,0,0));
        vecs.push_back(v(1,1,7,0, 6,1,0,0, 1,0, 0,0,0));   // flush kills dependent
        vecs.push_back(v(1,1,7,0, 6,1,0,0, 0,0, 1,0,0));
        vecs.push_back(v(1,1,7,0, 6,1,0,0, 0,0, 0,0,0));
        vecs.push_back(v(1,1,0,0, 0,0,0,0, 0,0, 0,0,0));   // writer r0
        vecs.push_back(v(1,1,1,0, 5,0,0,1, 0,0, 1,0,0));   // rt=r0, no exemption
        vecs.push_back(v(1,1,1,0, 5,0,0,1, 0,0, 1,0,0));
        vecs.push_back(v(1,1,1,0, 5,0,0,1, 0,0, 0,0,0));
        vecs.push_back(v(1,1,2,0, 0,0,0,0, 0,0, 0,0,0));
        vecs.push_back(v(1,0,0,0, 2,0,3,1, 0,0, 0,0,0));   // matching rs unused
        vecs.push_back(v(1,0,5,0, 0,0,0,0, 0,0, 0,0,0));   // wr=0 to r5
        vecs.push_back(v(1,1,1,0, 5,1,5,1, 0,0, 0,0,0));
        vecs.push_back(v(1,1,7,0, 0,0,0,0, 0,0, 0,0,0));
        vecs.push_back(v(0,1,7,0, 7,1,7,1, 0,0, 0,0,0));   // id_valid=0
        vecs.push_back(v(1,1,2,0, 0,0,0,0, 0,0, 0,0,0));
        for (int i = 0; i < 4; i++) vecs.push_back(v(1,1,3,0, 2,1,0,0, 0,1, 1,0,0));
        vecs.push_back(v(1,1,3,0, 2,1,0,0, 0,0, 1,0,0));
        vecs.push_back(v(1,1,3,0, 2,1,0,0, 0,0, 1,0,0));
        vecs.push_back(v(1,1,3,0, 2,1,0,0, 0,0, 0,0,0));
`else
        for (int i = 0; i < 2; i++) vecs.push_back(idle);
        vecs.push_back(v(1,1,3,0, 1,1,2,1, 0,0, 0,0,0));   // ADD r3
        vecs.push_back(v(1,1,4,0, 3,1,1,1, 0,0, 0,1,0));   // SUB bypass from EX
        vecs.push_back(v(1,1,3,0, 1,1,2,1, 0,0, 0,0,0));
        vecs.push_back(v(1,1,5,0, 1,1,2,1, 0,0, 0,0,0));   // unrelated
        vecs.push_back(v(1,1,6,0, 3,1,3,1, 0,0, 0,2,2));   // bypass from MEM
        vecs.push_back(v(1,1,2,0, 0,0,0,0, 0,0, 0,0,0));
        vecs.push_back(v(1,1,2,0, 0,0,0,0, 0,0, 0,0,0));
        vecs.push_back(v(1,1,7,0, 2,1,2,1, 0,0, 0,1,1));   // youngest wins
        vecs.push_back(v(1,1,5,1, 1,1,0,0, 0,0, 0,0,0));   // LD r5
        vecs.push_back(v(1,1,6,0, 5,1,0,0, 0,0, 1,0,0));   // load-use
        vecs.push_back(v(1,1,6,0, 5,1,0,0, 0,0, 0,2,0));
        vecs.push_back(v(1,1,1,1, 0,0,0,0, 0,0, 0,0,0));
        vecs.push_back(v(1,1,3,0, 1,1,0,0, 1,0, 0,0,0));   // flush
        vecs.push_back(v(1,1,3,0, 1,1,0,0, 0,0, 0,2,0));
        vecs.push_back(v(1,1,2,1, 0,0,0,0, 0,0, 0,0,0));
        for (int i = 0; i < 4; i++) vecs.push_back(v(1,1,3,0, 2,1,0,0, 0,1, 1,0,0));
        vecs.push_back(v(1,1,3,0, 2,1,0,0, 0,0, 1,0,0));
        vecs.push_back(v(1,1,3,0, 2,1,0,0, 0,0, 0,2,0));
        vecs.push_back(v(1,1,7,0, 0,0,0,0, 0,0, 0,0,0));
        vecs.push_back(v(0,0,0,0, 7,1,7,1, 0,0, 0,0,0));   // id_valid=0
        vecs.push_back(v(1,1,0,0, 0,0,0,0, 0,0, 0,0,0));   // writer r0
        vecs.push_back(v(1,1,1,0, 0,1,4,1, 0,0, 0,1,0));
`endif

        rst_n = 1'b0;
        drive(idle);
        model_reset();
        #12;
        chk("reset stall", int'(stall), 0);
        chk("reset fwd_a", int'(fwd_a_sel), 0);
        chk("reset fwd_b", int'(fwd_b_sel), 0);
        check_stages("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Asynchronous reset while a load-use hazard is stalling.
        run_vec(v(1,1,1,1, 0,0,0,0, 0,0, 0,0,0), 100);
        @(negedge clk);
        drive(v(1,1,2,0, 1,1,0,0, 0,0, 0,0,0));
        #1;
        chk("pre-reset stall", int'(stall), 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async stall", int'(stall), 0);
        check_stages("async");
        @(negedge clk);
        drive(idle);
        rst_n = 1'b1;

        // A self-dependent load held in ID stalls repeatedly; the counter must pin at 255.
        do_reset();
        drive(v(1,1,4,1, 4,1,0,0, 0,0, 0,0,0));
        for (int i = 0; i < 700; i++) @(posedge clk);
        #1;
        chk("saturate stall_cnt", int'(stall_cnt), 255);
        drive(idle);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dest_hazard_scoreboard.md
# dest_hazard_scoreboard

Tracks destination registers of in-flight instructions through the EX, MEM and WB pipeline stages. Each cycle it takes the 3-bit destination from the decode-stage destination decoder, plus the source registers of the instruction in ID. It raises a stall when a source depends on an uncommitted writer. It also provides the registered destination/write-enable for the writeback stage. With forwarding compiled in, it also produces the ALU operand-bypass selects.

## Interface
Parameters:
- CNT_W, 8, width of the saturating stall-cycle counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_wr_en  in  1  ID instruction writes a register
- id_rd  in  3  ID destination register (from destination decode)
- id_is_load  in  1  ID instruction is LD
- id_rs  in  3  first source register
- id_rs_used  in  1  first source is read
- id_rt  in  3  second source register
- id_rt_used  in  1  second source is read
- flush  in  1  taken branch/jump resolved; kill the ID instruction
- mem_stall  in  1  memory busy; freeze the whole pipeline
- stall  out  1  hold PC and IF/ID; insert bubble into EX (combinational)
- ex_rd, mem_rd, wb_rd  out  3 each  registered destination per stage
- ex_wr, mem_wr, wb_wr  out  1 each  registered write-enable per stage
- fwd_a_sel, fwd_b_sel  out  2 each  operand bypass select: 00 regfile, 01 from EX/MEM, 10 from MEM/WB
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Each stage entry holds {wr, rd, is_load}. A bubble is {0, 3'b000, 0}.
- R0 is a normal register. There is no zero-register exemption.
- Match rules:
  - A source matches a stage when the source is used, that stage's wr is 1, and the rd fields are equal.
  - id_valid=0 means no match.
- stall, without forwarding: 1 if any used source matches EX or MEM.
  - WB is not checked; the register file bypasses write-to-read in the same cycle.
- stall is forced to 0 when flush=1, because the ID instruction is dead.
- Cycle update when mem_stall=0:
  - WB <= MEM
  - MEM <= EX
  - EX <= bubble if (stall | flush | !id_valid), else {id_wr_en, id_rd, id_is_load}
- When mem_stall=1, all entries and stall_cnt hold their values.
- stall_cnt increments when stall=1 and mem_stall=0. It saturates at all-ones and never wraps.
- Simultaneous flush and stall condition: flush wins. The result is a bubble with stall=0.
- Reset mid-operation clears all entries and stall_cnt immediately (asynchronous). stall drops in the same cycle.

## Timing
- Reset values:
  - all ex_/mem_/wb_ outputs 0
  - stall_cnt 0
  - stall 0
  - fwd selects 00
- A writer in ID at cycle n is in EX at n+1, MEM at n+2, WB at n+3.
- Without forwarding, a consumer in ID at n+1 sees stall=1 in cycles n+1 and n+2. It advances at the end of n+3.
- stall and fwd_*_sel are combinational from the current entries and ID inputs. There are no registered outputs beyond the stage entries and stall_cnt.
- Back-to-back writers to the same rd: the youngest (EX) takes priority for forwarding.

## Configuration
- FORWARDING_EN defined:
  - stall=1 only when a used source matches EX and EX.is_load=1 (load-use).
  - fwd_x_sel=01 when the source matches EX and it is not a load.
  - fwd_x_sel=10 when the source matches MEM, and EX does not match.
  - Otherwise fwd_x_sel=00.
- FORWARDING_EN undefined:
  - Stall rules are as in Operation.
  - fwd_a_sel and fwd_b_sel are tied to 00.

## Test plan
- Reset then idle, id_valid=0 for 5 cycles:
  - All stage outputs stay 0; stall=0; stall_cnt=0.
- ADD writing r3, then SUB reading rs=r3 (no FORWARDING_EN):
  - stall=1 for exactly 2 cycles; stall_cnt=2.
  - A bubble appears in EX twice; SUB enters EX on the 3rd cycle.
  - wb_rd=3, wb_wr=1 three cycles after ADD left ID.
- Same sequence with FORWARDING_EN:
  - stall=0 and fwd_a_sel=01.
  - With one unrelated instruction inserted between them, fwd_a_sel=10.
- LD writing r5, then ADDI reading r5, with FORWARDING_EN:
  - stall=1 for 1 cycle, then fwd_a_sel=10; stall_cnt=1.
- Dependent in ID with flush=1:
  - stall=0; EX gets a bubble; stall_cnt unchanged.
- Hazard pending with mem_stall=1 held 4 cycles:
  - Entries and stall_cnt are frozen.
- rst_n pulsed low mid-stall:
  - All entries clear asynchronously and stall drops at once.
- Forced 300 stall cycles with CNT_W=8:
  - stall_cnt saturates at 255.
